// File: rtl/zx_video_pkg.sv
// Shared ZX screen geometry and copy-engine state encoding.
package zx_video_pkg;

  localparam int unsigned ADDR_W       = 13;
  localparam int unsigned PIX_BYTES    = 6144;
  localparam int unsigned ATTR_BASE    = PIX_BYTES;
  localparam int unsigned ATTR_BYTES   = 768;
  localparam int unsigned SCREEN_BYTES = ATTR_BASE + ATTR_BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2
  } copy_state_e;

endpackage

// File: rtl/zx_copy_pipe.sv
// Two-stage valid/address delay line that turns screen RAM copy reads into
// frame buffer writes once the read data returns.
module zx_copy_pipe #(
  parameter int unsigned ADDR_W = zx_video_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [7:0]        sp_dout,
  output logic [ADDR_W-1:0] fb_ada,
  output logic [7:0]        fb_din,
  output logic              fb_cea,
  output logic              pending_c
);

  logic              v1_q;
  logic              v2_q;
  logic [ADDR_W-1:0] a1_q;
  logic [ADDR_W-1:0] a2_q;

  assign pending_c = v1_q | v2_q;

  // Stage 1 = RAM sampling the address, stage 2 = read data on sp_dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      a1_q   <= '0;
      a2_q   <= '0;
      fb_ada <= '0;
      fb_din <= '0;
      fb_cea <= 1'b0;
    end else begin
      v1_q   <= issue;
      a1_q   <= issue_addr;
      v2_q   <= v1_q;
      a2_q   <= a1_q;
      fb_cea <= v2_q;
      if (v2_q) begin
        fb_ada <= a2_q;
        fb_din <= sp_dout;
      end
    end
  end

endmodule

// File: rtl/zx_screen_copy_arbiter.sv
// Per-frame copy of the ZX screen RAM into the display frame buffer, sharing
// the single-port screen RAM with CPU accesses (CPU first, copy never starves).
module zx_screen_copy_arbiter
  import zx_video_pkg::*;
#(
  parameter int unsigned SCREEN_BYTES = zx_video_pkg::SCREEN_BYTES,
  parameter int unsigned ADDR_W       = zx_video_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              copy_en,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] sp_ad,
  output logic [7:0]        sp_din,
  output logic              sp_wre,
  input  logic [7:0]        sp_dout,
  output logic [ADDR_W-1:0] fb_ada,
  output logic [7:0]        fb_din,
  output logic              fb_cea,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_BYTES - 1);

  copy_state_e       state_q;
  copy_state_e       state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              cpu_v1_q;
  logic              cpu_v2_q;
  logic              cpu_grant_c;
  logic              copy_issue_c;
  logic              frame_done_c;
  logic              overrun_c;
  logic              pipe_pending_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start && copy_en) state_d = COPY;
      COPY:    if (copy_issue_c && (rd_addr_q == LAST_ADDR)) state_d = DRAIN;
      DRAIN:   if (frame_done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A CPU op in flight (or being acked) blocks the next grant, so the copy
  // keeps at least two of every three slots.
  always_comb begin
    cpu_grant_c  = cpu_req && !cpu_v1_q && !cpu_v2_q;
    copy_issue_c = (state_q == COPY) && !cpu_grant_c;
    frame_done_c = (state_q == DRAIN) && !pipe_pending_c;
    overrun_c    = frame_start && (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q  <= '0;
      cpu_v1_q   <= 1'b0;
      cpu_v2_q   <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      sp_ad      <= '0;
      sp_din     <= '0;
      sp_wre     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sp_wre <= 1'b0;
      if (cpu_grant_c) begin
        sp_ad  <= cpu_addr;
        sp_din <= cpu_wdata;
        sp_wre <= cpu_we;
      end else if (copy_issue_c) begin
        sp_ad <= rd_addr_q;
      end

      if ((state_q == IDLE) && (state_d == COPY)) rd_addr_q <= '0;
      else if (copy_issue_c)                      rd_addr_q <= rd_addr_q + ADDR_W'(1);

      cpu_v1_q <= cpu_grant_c;
      cpu_v2_q <= cpu_v1_q;
      cpu_ack  <= cpu_v2_q;
      if (cpu_v2_q) cpu_rdata <= sp_dout;

      busy       <= (state_q != IDLE);
      frame_done <= frame_done_c;
      overrun    <= overrun_c;
    end
  end

  zx_copy_pipe #(
    .ADDR_W(ADDR_W)
  ) u_copy_pipe (
    .clk        (clk),
    .reset      (reset),
    .issue      (copy_issue_c),
    .issue_addr (rd_addr_q),
    .sp_dout    (sp_dout),
    .fb_ada     (fb_ada),
    .fb_din     (fb_din),
    .fb_cea     (fb_cea),
    .pending_c  (pipe_pending_c)
  );

endmodule

// File: tb/tb_zx_screen_copy_arbiter.sv
// Bench for zx_screen_copy_arbiter: screen RAM model, fb write monitor and a
// frame-level expectation model (frame buffer = screen image at copy time).
module tb_zx_screen_copy_arbiter;

  localparam int NB = 6912;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        copy_en = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [12:0] sp_ad;
  logic [7:0]  sp_din;
  logic        sp_wre;
  logic [7:0]  sp_dout;
  logic [12:0] fb_ada;
  logic [7:0]  fb_din;
  logic        fb_cea;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zx_screen_copy_arbiter dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .copy_en(copy_en),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .sp_ad(sp_ad), .sp_din(sp_din), .sp_wre(sp_wre), .sp_dout(sp_dout),
    .fb_ada(fb_ada), .fb_din(fb_din), .fb_cea(fb_cea),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  function automatic logic [7:0] pat(input int i, input logic [7:0] s);
    logic [12:0] a;
    a = 13'(i);
    return a[7:0] ^ a[12:5] ^ s;
  endfunction

  // Screen RAM: address sampled at a clock edge, data out after that edge.
  logic [7:0] scr [0:8191];
  logic       preload_req = 1'b0;
  logic [7:0] preload_seed = '0;
  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 8192; i++) scr[i] <= pat(i, preload_seed);
    end else if (sp_wre) begin
      scr[sp_ad] <= sp_din;
    end
    sp_dout <= scr[sp_ad];
  end

  // Output monitor, one sample per cycle just after the active edge.
  int   fb_a_q[$], fb_d_q[$], fb_c_q[$], done_q[$], ovr_q[$], ack_c_q[$], fall_q[$];
  logic busy_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (fb_cea === 1'b1) begin
      fb_a_q.push_back(int'(fb_ada));
      fb_d_q.push_back(int'(fb_din));
      fb_c_q.push_back(cyc);
    end
    if (frame_done === 1'b1) done_q.push_back(cyc);
    if (overrun === 1'b1) ovr_q.push_back(cyc);
    if (cpu_ack === 1'b1) ack_c_q.push_back(cyc);
    if (busy_prev && (busy !== 1'b1)) fall_q.push_back(cyc);
    busy_prev = (busy === 1'b1);
  end

  logic [7:0] exp_mem [0:8191];
  logic [7:0] frame_exp [0:NB-1];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [7:0] seed);
    preload_seed = seed;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
    for (int i = 0; i < 8192; i++) exp_mem[i] = pat(i, seed);
  endtask

  task automatic start_frame(output int t0);
    for (int i = 0; i < NB; i++) frame_exp[i] = exp_mem[i];
    copy_en = 1'b1;
    frame_start = 1'b1;
    t0 = cyc + 1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    for (int i = 0; i < budget && done_q.size() <= base; i++) tick();
    ok = (done_q.size() > base);
  endtask

  task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output bit ok);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (cpu_ack === 1'b1) begin ok = 1'b1; rd = cpu_rdata; end
    end
    cpu_req = 1'b0;
  endtask

  // Counts fb writes that deviate from a linear copy of frame_exp.
  function automatic int fb_bad(input int base, input int t0, input bit timed);
    int bad = 0;
    for (int i = 0; i < NB; i++) begin
      if (base + i >= fb_a_q.size()) bad++;
      else if (fb_a_q[base+i] != i || fb_d_q[base+i] != int'(frame_exp[i]) ||
               (timed && fb_c_q[base+i] != t0 + 3 + i)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    int nfb;
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({cpu_ack, cpu_rdata, sp_ad, sp_din, sp_wre, fb_ada, fb_din, fb_cea, busy, frame_done, overrun} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got ack=%b rd=%h ad=%h din=%h wre=%b fa=%h fd=%h cea=%b busy=%b done=%b ovr=%b, want all 0",
        cpu_ack, cpu_rdata, sp_ad, sp_din, sp_wre, fb_ada, fb_din, fb_cea, busy, frame_done, overrun);
    end
    reset = 1'b0;
    tick();
    nfb = fb_a_q.size();
    copy_en = 1'b0; frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (busy !== 1'b0 || fb_a_q.size() != nfb) begin
      n_bad++; $display("FAIL start_without_copy_en: busy=%b fb_writes=%0d, want busy=0 fb_writes=0", busy, fb_a_q.size() - nfb);
    end
  endtask

  task automatic test_cpu_idle();
    logic [7:0] rd;
    bit ok;
    logic [12:0] a;
    logic [7:0] d;
    logic we;
    preload(8'h00);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd100; cpu_wdata = 8'h5A;
    tick();
    n_cmp++;
    if (sp_wre !== 1'b1 || sp_ad !== 13'd100 || sp_din !== 8'h5A) begin
      n_bad++; $display("FAIL cpu_write_slot: wre=%b ad=%0d din=%h, want 1 100 5a", sp_wre, sp_ad, sp_din);
    end
    tick();
    n_cmp++;
    if (sp_wre !== 1'b0 || cpu_ack !== 1'b0) begin
      n_bad++; $display("FAIL cpu_write_one_slot: wre=%b ack=%b, want 0 0", sp_wre, cpu_ack);
    end
    tick();
    cpu_req = 1'b0;
    n_cmp++;
    if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL cpu_write_ack: ack=%b, want 1", cpu_ack); end
    exp_mem[100] = 8'h5A;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd100;
    tick();
    n_cmp++;
    if (sp_ad !== 13'd100 || sp_wre !== 1'b0 || cpu_ack !== 1'b0) begin
      n_bad++; $display("FAIL cpu_read_grant: ad=%0d wre=%b ack=%b, want 100 0 0", sp_ad, sp_wre, cpu_ack);
    end
    tick();
    n_cmp++;
    if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL cpu_read_early_ack: ack=%b, want 0", cpu_ack); end
    tick();
    cpu_req = 1'b0;
    n_cmp++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== exp_mem[100]) begin
      n_bad++; $display("FAIL cpu_read_ack: ack=%b rdata=%h, want 1 %h", cpu_ack, cpu_rdata, exp_mem[100]);
    end
    tick();
    n_cmp++;
    if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL cpu_ack_pulse: ack=%b, want 0", cpu_ack); end
    for (int k = 0; k < 10; k++) begin
      we = 1'($urandom_range(1));
      a = 13'($urandom_range(8191));
      d = 8'($urandom);
      cpu_op(we, a, d, rd, ok);
      n_cmp++;
      if (!ok || (!we && rd !== exp_mem[a])) begin
        n_bad++; $display("FAIL cpu_random_op%0d: we=%b addr=%0d ok=%b rdata=%h, want ok=1 rdata=%h", k, we, a, ok, rd, exp_mem[a]);
      end
      if (we) exp_mem[a] = d;
    end
  endtask

  task automatic test_full_copy();
    int t0, bfb, bdone, bfall, bovr, bad;
    bit ok;
    bfb = fb_a_q.size(); bdone = done_q.size(); bfall = fall_q.size(); bovr = ovr_q.size();
    start_frame(t0);
    wait_done(bdone, 8000, ok);
    repeat (3) tick();
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL full_done_timeout: no frame_done, want one"); end
    n_cmp++;
    if (fb_a_q.size() - bfb != NB) begin
      n_bad++; $display("FAIL full_fb_count: got %0d writes, want %0d", fb_a_q.size() - bfb, NB);
    end
    bad = fb_bad(bfb, t0, 1'b1);
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL full_fb_content: %0d bad writes, want 0", bad); end
    n_cmp++;
    if (!ok || done_q[bdone] != t0 + 6915) begin
      n_bad++; $display("FAIL full_done_cycle: got %0d, want %0d", ok ? done_q[bdone] - t0 : -1, 6915);
    end
    n_cmp++;
    if (fall_q.size() <= bfall || fall_q[bfall] != t0 + 6916) begin
      n_bad++; $display("FAIL full_busy_fall: got %0d, want %0d", fall_q.size() > bfall ? fall_q[bfall] - t0 : -1, 6916);
    end
    n_cmp++;
    if (ovr_q.size() != bovr) begin n_bad++; $display("FAIL full_no_overrun: %0d overruns, want 0", ovr_q.size() - bovr); end
  endtask

  task automatic test_cpu_write_mid_copy();
    int t0, bfb, bdone, bad;
    bit ok;
    logic [7:0] rd, d, old5;
    logic [12:0] a;
    preload(8'($urandom));
    bfb = fb_a_q.size(); bdone = done_q.size();
    start_frame(t0);
    while (cyc < t0 + 100) tick();
    cpu_op(1'b1, 13'd6144, 8'hFF, rd, ok);
    exp_mem[6144] = 8'hFF; frame_exp[6144] = 8'hFF;
    a = 13'($urandom_range(6911, 6600)); d = 8'($urandom);
    cpu_op(1'b1, a, d, rd, ok);
    exp_mem[a] = d; frame_exp[a] = d;
    old5 = exp_mem[5];
    cpu_op(1'b1, 13'd5, ~old5, rd, ok);
    exp_mem[5] = ~old5;
    a = 13'($urandom_range(8191, 6912)); d = 8'($urandom);
    cpu_op(1'b1, a, d, rd, ok);
    exp_mem[a] = d;
    cpu_op(1'b0, 13'd6144, 8'h00, rd, ok);
    n_cmp++;
    if (!ok || rd !== 8'hFF) begin n_bad++; $display("FAIL mid_readback: ok=%b rdata=%h, want 1 ff", ok, rd); end
    wait_done(bdone, 8000, ok);
    repeat (3) tick();
    n_cmp++;
    if (!ok || fb_a_q.size() - bfb != NB) begin
      n_bad++; $display("FAIL mid_fb_count: done=%b writes=%0d, want 1 %0d", ok, fb_a_q.size() - bfb, NB);
    end
    bad = fb_bad(bfb, t0, 1'b0);
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL mid_fb_content: %0d bad writes, want 0", bad); end
    n_cmp++;
    if (fb_a_q.size() > bfb + 6144 && fb_d_q[bfb+6144] != 8'hFF) begin
      n_bad++; $display("FAIL mid_attr_write: got %h, want ff", fb_d_q[bfb+6144]);
    end
    n_cmp++;
    if (fb_a_q.size() > bfb + 5 && fb_d_q[bfb+5] != int'(old5)) begin
      n_bad++; $display("FAIL mid_behind_write: got %h, want old %h", fb_d_q[bfb+5], old5);
    end
    bfb = fb_a_q.size(); bdone = done_q.size();
    start_frame(t0);
    wait_done(bdone, 8000, ok);
    repeat (3) tick();
    bad = fb_bad(bfb, t0, 1'b1);
    n_cmp++;
    if (!ok || bad != 0) begin n_bad++; $display("FAIL next_frame_content: done=%b bad=%0d, want 1 0", ok, bad); end
    n_cmp++;
    if (fb_a_q.size() > bfb + 5 && fb_d_q[bfb+5] != int'(exp_mem[5])) begin
      n_bad++; $display("FAIL next_frame_behind_write: got %h, want %h", fb_d_q[bfb+5], exp_mem[5]);
    end
  endtask

  task automatic test_cpu_hog();
    int t0, bfb, bdone, back, bad, rd_bad, gap_bad, nack;
    bit ok, done_seen;
    logic [7:0] want;
    bit cur_we;
    bfb = fb_a_q.size(); bdone = done_q.size(); back = ack_c_q.size();
    rd_bad = 0; done_seen = 1'b0;
    cur_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'($urandom_range(8191, 6912));
    want = exp_mem[cpu_addr];
    start_frame(t0);
    for (int i = 0; i < 10500; i++) begin
      tick();
      if (done_q.size() > bdone) done_seen = 1'b1;
      if (cpu_ack === 1'b1) begin
        if (!cur_we && cpu_rdata !== want) rd_bad++;
        if (done_seen) break;
        cur_we = 1'($urandom_range(3) == 0);
        cpu_we = cur_we;
        cpu_addr = 13'($urandom_range(8191, 6912));
        cpu_wdata = 8'($urandom);
        want = exp_mem[cpu_addr];
        if (cur_we) exp_mem[cpu_addr] = cpu_wdata;
      end
    end
    cpu_req = 1'b0;
    repeat (4) tick();
    ok = (done_q.size() == bdone + 1);
    n_cmp++;
    if (!ok || done_q[bdone] - t0 > 10372) begin
      n_bad++; $display("FAIL hog_done: count=%0d cycles=%0d, want 1 <=10372", done_q.size() - bdone,
        done_q.size() > bdone ? done_q[bdone] - t0 : -1);
    end
    gap_bad = 0;
    nack = ack_c_q.size() - back;
    for (int i = back + 1; i < ack_c_q.size(); i++) if (ack_c_q[i] - ack_c_q[i-1] != 3) gap_bad++;
    n_cmp++;
    if (gap_bad != 0 || nack < NB / 2) begin
      n_bad++; $display("FAIL hog_grant_rate: acks=%0d bad_gaps=%0d, want >=%0d 0", nack, gap_bad, NB / 2);
    end
    n_cmp++;
    if (rd_bad != 0) begin n_bad++; $display("FAIL hog_read_data: %0d bad reads, want 0", rd_bad); end
    bad = fb_bad(bfb, t0, 1'b0);
    n_cmp++;
    if (bad != 0 || fb_a_q.size() - bfb != NB) begin
      n_bad++; $display("FAIL hog_fb: bad=%0d writes=%0d, want 0 %0d", bad, fb_a_q.size() - bfb, NB);
    end
  endtask

  task automatic test_overrun();
    int t0, bfb, bdone, bovr, bad;
    bit ok;
    preload(8'($urandom));
    bfb = fb_a_q.size(); bdone = done_q.size(); bovr = ovr_q.size();
    start_frame(t0);
    while (cyc < t0 + 1000) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(bdone, 8000, ok);
    repeat (8) tick();
    n_cmp++;
    if (ovr_q.size() != bovr + 1 || ovr_q[bovr] != t0 + 1001) begin
      n_bad++; $display("FAIL overrun_pulse: count=%0d cycle=%0d, want 1 1001", ovr_q.size() - bovr,
        ovr_q.size() > bovr ? ovr_q[bovr] - t0 : -1);
    end
    n_cmp++;
    if (done_q.size() != bdone + 1 || done_q[bdone] != t0 + 6915) begin
      n_bad++; $display("FAIL overrun_done: count=%0d cycle=%0d, want 1 6915", done_q.size() - bdone,
        done_q.size() > bdone ? done_q[bdone] - t0 : -1);
    end
    bad = fb_bad(bfb, t0, 1'b1);
    n_cmp++;
    if (bad != 0 || fb_a_q.size() - bfb != NB) begin
      n_bad++; $display("FAIL overrun_fb: bad=%0d writes=%0d, want 0 %0d", bad, fb_a_q.size() - bfb, NB);
    end
  endtask

  task automatic test_reset_mid_copy();
    int t0, bfb, bdone, back, late, bad;
    bit ok;
    bdone = done_q.size(); back = ack_c_q.size();
    start_frame(t0);
    while (cyc < t0 + 498) tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'($urandom_range(8191));
    tick();
    cpu_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({cpu_ack, cpu_rdata, sp_ad, sp_din, sp_wre, fb_ada, fb_din, fb_cea, busy, frame_done, overrun} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs: ack=%b rd=%h ad=%h wre=%b fa=%h fd=%h cea=%b busy=%b done=%b, want all 0",
        cpu_ack, cpu_rdata, sp_ad, sp_wre, fb_ada, fb_din, fb_cea, busy, frame_done);
    end
    repeat (30) tick();
    late = 0;
    for (int i = 0; i < fb_c_q.size(); i++) if (fb_c_q[i] > t0 + 500) late++;
    n_cmp++;
    if (late != 0 || done_q.size() != bdone || ack_c_q.size() != back || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_abandon: fb=%0d done=%0d acks=%0d busy=%b, want 0 0 0 0",
        late, done_q.size() - bdone, ack_c_q.size() - back, busy);
    end
    bfb = fb_a_q.size(); bdone = done_q.size();
    start_frame(t0);
    wait_done(bdone, 8000, ok);
    repeat (3) tick();
    bad = fb_bad(bfb, t0, 1'b1);
    n_cmp++;
    if (!ok || bad != 0 || fb_a_q.size() - bfb != NB) begin
      n_bad++; $display("FAIL after_reset_copy: done=%b bad=%0d writes=%0d, want 1 0 %0d", ok, bad, fb_a_q.size() - bfb, NB);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_idle();
    test_full_copy();
    test_cpu_write_mid_copy();
    test_cpu_hog();
    test_overrun();
    test_reset_mid_copy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zx_screen_copy_arbiter.md
Name: zx_screen_copy_arbiter

Overview:
Sequences the once-per-frame copy of the 6912-byte ZX screen image (6144 pixel bytes, then 768 attribute bytes) from the single-port CPU-side screen RAM into the write port of the dual-port display frame buffer.
It also arbitrates the single-port screen RAM between CPU reads/writes and the copy engine. CPU accesses have priority, and the copy engine is guaranteed forward progress.
It sits between the CPU bus, the Gowin_SP screen RAM and the write side (ada/din/cea) of the Gowin_SDPB frame buffer read by the pixel pipeline.

Parameters:
SCREEN_BYTES, 6912, total bytes copied per frame (pixels + attributes, linear address range 0..SCREEN_BYTES-1)
ADDR_W, 13, address width of both RAMs

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle pulse at start of vertical blanking
copy_en  in  1  gates starting a new copy; does not abort a copy in progress
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid while cpu_ack=1
sp_ad  out  ADDR_W  screen RAM address (registered)
sp_din  out  8  screen RAM write data (registered)
sp_wre  out  1  screen RAM write enable (registered)
sp_dout  in  8  screen RAM read data, valid 1 cycle after the RAM samples the address
fb_ada  out  ADDR_W  frame buffer write address (registered)
fb_din  out  8  frame buffer write data (registered)
fb_cea  out  1  frame buffer write enable (registered)
busy  out  1  1 while state != IDLE
frame_done  out  1  one-cycle pulse after the last frame buffer write
overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset values: all outputs 0. State IDLE, copy counter 0, pipeline valid bits 0, no CPU op outstanding. A reset in mid-operation abandons the copy and any CPU op: no frame_done, no cpu_ack.
- Screen RAM slot issued at edge k: the sp_* registers update at k, the RAM samples at k+1, and sp_dout is captured at k+2. Issue-to-result latency is 2 cycles for both requesters.
- State machine:
  - IDLE: frame_start & copy_en -> COPY, rd_addr=0. frame_start & !copy_en is ignored.
  - COPY: on each edge where the slot is not given to the CPU, issue a read at rd_addr and increment rd_addr. When rd_addr = SCREEN_BYTES-1 is issued -> DRAIN.
  - DRAIN: wait for the last copy read to be written. Then frame_done=1 for 1 cycle and go to IDLE.
- Copy pipeline: a 2-stage valid/address shift tracks each copy read. On capture: fb_ada = delayed address, fb_din = sp_dout, fb_cea = 1. Otherwise fb_cea = 0.
- Frame buffer write order is strictly linear 0..SCREEN_BYTES-1. The ZX interleaved layout is identical in both RAMs, so no address remapping is done.
- Arbitration:
  - cpu_req is granted at edge k when no CPU op is outstanding and no cpu_ack is being issued at k; the CPU then takes the slot at k.
  - cpu_ack is pulsed at k+2, with cpu_rdata = sp_dout for reads (undefined, but stable, for writes).
  - The earliest next grant is k+3, so the copy always receives at least 2 of every 3 slots.
  - A CPU write sets sp_wre=1 for exactly its slot. Copy reads and CPU reads set sp_wre=0.
- CPU write to an address already copied this frame: visible next frame. Not yet copied: visible this frame.
- frame_start while busy: overrun pulse; the copy is neither restarted nor extended.
- Deasserting copy_en mid-copy: the current frame completes normally.
- cpu_addr >= SCREEN_BYTES: executed normally; never touched by the copy.

Decomposition:
- Package zx_video_pkg: SCREEN_BYTES, PIX_BYTES=6144, ATTR_BASE=6144, ADDR_W, and the state enum {IDLE, COPY, DRAIN}.
- One sub-module is natural: zx_copy_pipe, the 2-stage valid/address delay line that generates fb_ada/fb_din/fb_cea.

Test Plan:
- Preload screen RAM with data = addr[7:0]^addr[12:5]; frame_start at edge t0, no CPU activity -> 6912 fb writes at t0+3..t0+6914 with addresses 0..6911 in order and matching data; frame_done at t0+6915; busy low at t0+6916.
- CPU read of addr 100 (data 0x5A) while IDLE -> sp_ad=100 at grant edge, cpu_ack at +2 with cpu_rdata=0x5A, sp_wre=0.
- CPU write 0xFF to addr 6144 mid-copy before that address is reached -> fb write at 6144 carries 0xFF; copy address sequence has no gaps or duplicates.
- cpu_req held high during the whole copy -> grants every 3rd cycle, all 6912 fb writes still correct, frame_done within 10372 cycles of frame_start.
- frame_start again at t0+1000 -> overrun pulse at t0+1001, copy continues, exactly one frame_done.
- reset asserted at t0+500 for 1 cycle -> all outputs 0 next cycle, no frame_done; the next frame_start runs a full copy from address 0.
